// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: operands are latched on an input handshake.
// The block then consumes DIGIT bits per cycle, LSB first, and presents the
// WIDTH-bit result with carry-out and signed overflow on a valid/ready output.
module digit_serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int DW    = DIGIT + 1;
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  // Operand sign bits are kept aside because the operand registers shift.
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;

  logic [DIGIT:0]     dsum;
  logic [WIDTH-1:0]   res_next;

  // Digit slice adder and result shift-in from the MSB side.
  always_comb begin
    dsum     = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + DW'(carry_q);
    res_next = WIDTH'({dsum[DIGIT-1:0], res_q} >> DIGIT);
  end

  // Next-state logic for the control FSM and the serial datapath.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is a + ~b + ~cin, so borrow-in maps onto carry-in.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? ~cin : cin;
          a_msb_d = a[WIDTH-1];
          b_msb_d = sub ? ~b[WIDTH-1] : b[WIDTH-1];
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = dsum[DIGIT];
        res_d   = res_next;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_DIG) begin
          sum_d   = res_next;
          cout_d  = dsum[DIGIT];
          ovf_d   = (a_msb_q == b_msb_q) && (res_next[WIDTH-1] != a_msb_q);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset wins over any concurrent handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: directed table and hand sequences on the
// default 8/2 configuration, random ops on 8/2, 32/4 and 8/8 against a
// plain-arithmetic reference model.
module tb_digit_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic       c;
    logic [7:0] es;
    logic       ec;
    logic       eo;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: integer a+b+cin or a-b-cin, carry/borrow and signed range test.
  function automatic res_t model(input int w, input longint unsigned ua, input longint unsigned ub,
                                 input bit s, input bit c);
    res_t r;
    longint unsigned mask, full;
    longint sa, sb, sr, hi, lo;
    mask = (64'd1 << w) - 64'd1;
    sa = ((ua >> (w - 1)) & 64'd1) != 0 ? longint'(ua) - (longint'(1) << w) : longint'(ua);
    sb = ((ub >> (w - 1)) & 64'd1) != 0 ? longint'(ub) - (longint'(1) << w) : longint'(ub);
    if (!s) begin
      full   = ua + ub + 64'(c);
      r.sum  = full & mask;
      r.cout = ((full >> w) & 64'd1) != 0;
      sr     = sa + sb + longint'(c);
    end else begin
      full   = ua - ub - 64'(c);
      r.sum  = full & mask;
      r.cout = (ua >= ub + 64'(c));
      sr     = sa - sb - longint'(c);
    end
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    r.ovf = (sr > hi) || (sr < lo);
    return r;
  endfunction

  // ---------------- default configuration WIDTH=8, DIGIT=2 ----------------
  logic       rst, in_valid, in_ready, sub, cin, out_valid, out_ready, cout, ovf;
  logic [7:0] a, b, sum;

  digit_serial_adder #(.WIDTH(8), .DIGIT(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  task automatic run_op8(input logic [7:0] ia, input logic [7:0] ib, input logic is, input logic ic,
                         input int hold, output logic [7:0] rs, output logic rc, output logic ro,
                         output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    a = ia; b = ib; sub = is; cin = ic; in_valid = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs while the operation is in flight.
    in_valid = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
    sub = 1'($urandom); cin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
      in_valid = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
    end
    rs = sum; rc = cout; ro = ovf;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom);
      @(posedge clk); #1;
      check("hold_valid_ready", 64'({out_valid, in_ready}), 64'(2'b10));
      check("hold_result", 64'({sum, cout, ovf}), 64'({rs, rc, ro}));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    check("idle_after_release", 64'({out_valid, in_ready}), 64'(2'b01));
  endtask

  vec_t vecs[11];

  initial begin
    logic [7:0] rs;
    logic       rc, ro, pulse;
    int         lat, guard;
    res_t       m;

    vecs[0]  = '{8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0};
    vecs[1]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3]  = '{8'h10, 8'h20, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0};
    vecs[4]  = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1};
    vecs[5]  = '{8'h01, 8'h01, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};
    vecs[6]  = '{8'h05, 8'h03, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[7]  = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[8]  = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[9]  = '{8'h7F, 8'hFF, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[10] = '{8'hFF, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0};

    // Reset held with a pending request: nothing may be accepted.
    rst = 1'b1; in_valid = 1'b1; a = 8'h12; b = 8'h34; sub = 1'b0; cin = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_outputs", 64'({out_valid, sum, cout, ovf}), 64'(0));
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle", 64'({in_ready, out_valid}), 64'(2'b10));

    // Directed vector table.
    for (int i = 0; i < 11; i++) begin
      run_op8(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c, 0, rs, rc, ro, lat);
      check($sformatf("vec%0d_sum", i), 64'(rs), 64'(vecs[i].es));
      check($sformatf("vec%0d_cout", i), 64'(rc), 64'(vecs[i].ec));
      check($sformatf("vec%0d_ovf", i), 64'(ro), 64'(vecs[i].eo));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(4));
    end

    // Results persist through IDLE and a following RUN until the next DONE.
    check("sum_kept_in_idle", 64'({sum, cout, ovf}), 64'({8'hFF, 1'b1, 1'b0}));

    // Backpressure for 5 cycles with new requests offered.
    run_op8(8'h35, 8'h4A, 1'b0, 1'b0, 5, rs, rc, ro, lat);
    check("bp_sum", 64'({rs, rc, ro}), 64'({8'h7F, 1'b0, 1'b0}));

    // Reset during the 2nd RUN cycle discards the operation.
    a = 8'h11; b = 8'h22; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mid_run_busy", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_run_state", 64'({in_ready, out_valid}), 64'(2'b10));
    check("rst_run_result", 64'({sum, cout, ovf}), 64'(0));
    pulse = 1'b0;
    repeat (8) begin @(posedge clk); #1; if (out_valid) pulse = 1'b1; end
    check("no_pulse_after_rst", 64'(pulse), 64'(0));

    // Random ops on the default configuration.
    for (int k = 0; k < 200; k++) begin
      logic [7:0] ra, rb;
      logic rsb, rci;
      ra = 8'($urandom); rb = 8'($urandom); rsb = 1'($urandom); rci = 1'($urandom);
      run_op8(ra, rb, rsb, rci, int'($urandom_range(0, 2)), rs, rc, ro, lat);
      m = model(8, 64'(ra), 64'(rb), rsb, rci);
      check("rnd8_result", 64'({rs, rc, ro}), 64'({m.sum[7:0], m.cout, m.ovf}));
      check("rnd8_latency", 64'(lat), 64'(4));
    end

    guard = 0;
    while (!(g_sweep[0].done_f && g_sweep[1].done_f) && guard < 40000) begin
      @(posedge clk); guard++;
    end
    check("sweep_finished", 64'({g_sweep[0].done_f, g_sweep[1].done_f}), 64'(2'b11));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // ---------------- parameter sweep: (32,4) and (8,8) ----------------
  for (genvar g = 0; g < 2; g++) begin : g_sweep
    localparam int W = (g == 0) ? 32 : 8;
    localparam int D = (g == 0) ? 4 : 8;
    localparam int N = W / D;

    logic         rst_s, iv, ir, sb_s, ci, ov, ordy, co, of;
    logic [W-1:0] sa, sbv, ss;
    bit           done_f = 1'b0;

    digit_serial_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk(clk), .rst(rst_s), .in_valid(iv), .in_ready(ir),
      .a(sa), .b(sbv), .sub(sb_s), .cin(ci),
      .out_valid(ov), .out_ready(ordy),
      .sum(ss), .cout(co), .ovf(of)
    );

    initial begin
      logic [W-1:0] xa, xb;
      logic         xs, xc;
      int           lat, guard;
      res_t         m;
      rst_s = 1'b1; iv = 1'b0; ordy = 1'b0; sa = '0; sbv = '0; sb_s = 1'b0; ci = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_s = 1'b0;
      for (int k = 0; k < 1000; k++) begin
        xa = W'($urandom); xb = W'($urandom); xs = 1'($urandom); xc = 1'($urandom);
        guard = 0;
        while (!ir && guard < 50) begin @(posedge clk); #1; guard++; end
        sa = xa; sbv = xb; sb_s = xs; ci = xc; iv = 1'b1;
        @(posedge clk); #1;
        iv = 1'($urandom); sa = W'($urandom); sbv = W'($urandom); sb_s = 1'($urandom);
        lat = 0;
        while (!ov && lat < 100) begin @(posedge clk); #1; lat++; end
        m = model(W, 64'(xa), 64'(xb), xs, xc);
        check($sformatf("sweep%0d_result", W * 100 + D), 64'({ss, co, of}),
              64'({m.sum[W-1:0], m.cout, m.ovf}));
        check($sformatf("sweep%0d_latency", W * 100 + D), 64'(lat), 64'(N));
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0; iv = 1'b0;
      end
      done_f = 1'b1;
    end
  end

endmodule

// File: doc/digit_serial_adder.md
DIGIT_SERIAL_ADDER -- requirements
Module: digit_serial_adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning operand and result width in bits.
REQ-002 The module SHALL have parameter DIGIT, default 2, meaning bits processed per cycle; WIDTH % DIGIT == 0 and 1 <= DIGIT <= WIDTH are required, and NDIG = WIDTH/DIGIT.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  operand request valid.
REQ-006 in_ready  output  1  block can accept an operand request.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 sub  input  1  0 = add, 1 = subtract.
REQ-010 cin  input  1  carry-in (add) / borrow-in (subtract).
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  carry-out; for subtract, 1 = no borrow.
REQ-015 ovf  output  1  two's-complement signed overflow.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-017 In IDLE, in_ready SHALL be 1; in all other states it SHALL be 0.
REQ-018 An input handshake (in_valid & in_ready at a rising edge) SHALL latch a, b' = sub ? ~b : b, and carry = sub ? ~cin : cin, clear the digit counter, and move the FSM to RUN.
REQ-019 Each RUN cycle SHALL add the low DIGIT bits of the A and b' shift registers plus carry, shift the DIGIT result bits into the result register from the MSB side, update carry, shift both operands right by DIGIT, and increment the digit counter.
REQ-020 After the NDIG-th RUN cycle, the FSM SHALL move to DONE and load sum, cout (the final carry) and ovf in the same edge.
REQ-021 ovf SHALL be (A[MSB] == b'[MSB]) & (sum[MSB] != A[MSB]), evaluated on the latched operands.
REQ-022 out_valid SHALL be 1 only in DONE, asserting exactly NDIG cycles after the accepting edge.
REQ-023 DONE with out_ready = 1 at an edge SHALL return the FSM to IDLE; sustained throughput is one operation per NDIG+2 cycles.
REQ-024 While out_valid = 1 and out_ready = 0, sum, cout, ovf and out_valid SHALL hold stable.
REQ-025 sum, cout and ovf SHALL change only on entry to DONE or on reset, and SHALL keep the last result through IDLE and RUN.
REQ-026 in_valid, a, b, sub and cin SHALL be ignored outside IDLE, and changes to them during RUN SHALL NOT affect the result in flight.
REQ-027 Arithmetic SHALL be modulo 2^WIDTH: add gives a + b + cin, and subtract gives a - b - cin.
REQ-028 When DIGIT == WIDTH, RUN SHALL last exactly one cycle.

Reset
REQ-029 When rst = 1 at an edge, the FSM SHALL go to IDLE with in_ready = 1, out_valid = 0, sum = 0, cout = 0, ovf = 0, carry, counter and operand registers cleared.
REQ-030 Reset SHALL take priority over any concurrent handshake, and an operation in RUN or DONE SHALL be discarded without producing a result.
REQ-031 While rst = 1, in_ready SHALL still read 1 after the first reset edge, but no handshake SHALL be accepted.

Verification (WIDTH=8, DIGIT=2, NDIG=4 unless stated)
REQ-032 Add, a=35h, b=4Ah, sub=0, cin=0 -> sum=7Fh, cout=0, ovf=0; out_valid rises 4 cycles after the accept edge.
REQ-033 Carry wrap: a=FFh, b=01h, cin=0 -> sum=00h, cout=1, ovf=0; and a=7Fh, b=01h -> sum=80h, cout=0, ovf=1.
REQ-034 Subtract, a=10h, b=20h, sub=1, cin=0 -> sum=F0h, cout=0, ovf=0; and a=80h, b=01h, sub=1 -> sum=7Fh, cout=1, ovf=1.
REQ-035 Backpressure: out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands -> out_valid, sum, cout and ovf are held, in_ready=0, and nothing is accepted; when out_ready=1, the FSM is in IDLE next cycle.
REQ-036 Reset in the 2nd RUN cycle -> the next cycle has in_ready=1, out_valid=0 and sum=00h, and no out_valid pulse follows.
REQ-037 Parameter sweep with (WIDTH=32, DIGIT=4) and (WIDTH=8, DIGIT=8) -> 1000 random ops each match the reference model a±b±cin with correct cout and ovf, and latency is 8 and 1 cycles respectively.
